// File: rtl/id_ex_if.sv
// ID/EX pipeline bus: decode-side bundle, register file read data and
// writeback port going in; registered EX bundle, load-use stall and bubble
// count coming out. master = decode/regfile side, slave = the ID/EX stage.
interface id_ex_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] id_imm;
  logic [3:0]  id_alu_op;
  logic        id_alu_src;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_reg_write;
  logic        flush;

  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        stall_id;
  logic [15:0] hazard_count;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_alu_op,
           id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           read_data1, read_data2, wb_rd, wb_data, wb_reg_write, flush,
    input  ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_rs1, ex_rs2, ex_rd,
           ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
           stall_id, hazard_count
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_alu_op,
           id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           read_data1, read_data2, wb_rd, wb_data, wb_reg_write, flush,
    output ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_rs1, ex_rs2, ex_rd,
           ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
           stall_id, hazard_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass and load-use bubble insertion.
// Latency: one cycle decode -> EX; stall_id is the only combinational output.
// Backpressure: stall_id holds decode/fetch; a bubble enters EX meanwhile.
// Ports: clk, reset (sync, active high), bus (id_ex_if.slave) carrying the
// decode bundle, regfile data, writeback port, flush and the EX outputs.
module id_ex_stage #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  id_ex_if.slave   bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_t;

  ex_t         ex_q;
  logic [15:0] hc_q;
  logic        stall;
  logic        rd_hit;

  // x0 reads as zero no matter what the regfile or writeback port shows;
  // since rs is nonzero past the first test, wb_rd == rs also excludes x0.
  function automatic logic [31:0] pick_op(input logic [4:0]  rs,
                                          input logic [31:0] rf_data,
                                          input logic        wb_we,
                                          input logic [4:0]  wb_rd,
                                          input logic [31:0] wb_data);
    if (rs == 5'd0)
      return 32'd0;
    if (BYPASS_EN && wb_we && (wb_rd == rs))
      return wb_data;
    return rf_data;
  endfunction

  // Load-use check ignores bypass entirely: the loaded value is not yet on
  // the writeback port. Flush and reset both kill the decode slot.
  always_comb begin
    rd_hit = (ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2);
    stall  = bus.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0)
             && rd_hit && !bus.flush && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
      hc_q <= '0;
    end else if (bus.flush || stall) begin
      // Bubble: only the side-effect controls must be cleared.
      ex_q.valid     <= 1'b0;
      ex_q.reg_write <= 1'b0;
      ex_q.mem_read  <= 1'b0;
      ex_q.mem_write <= 1'b0;
      if (!bus.flush && (hc_q != 16'hFFFF))
        hc_q <= hc_q + 16'd1;
    end else begin
      ex_q <= '{
        valid:     bus.id_valid,
        pc:        bus.id_pc,
        imm:       bus.id_imm,
        op1:       pick_op(bus.id_rs1, bus.read_data1, bus.wb_reg_write,
                           bus.wb_rd, bus.wb_data),
        op2:       pick_op(bus.id_rs2, bus.read_data2, bus.wb_reg_write,
                           bus.wb_rd, bus.wb_data),
        rs1:       bus.id_rs1,
        rs2:       bus.id_rs2,
        rd:        bus.id_rd,
        alu_op:    bus.id_alu_op,
        alu_src:   bus.id_alu_src,
        reg_write: bus.id_reg_write && bus.id_valid,
        mem_read:  bus.id_mem_read  && bus.id_valid,
        mem_write: bus.id_mem_write && bus.id_valid
      };
    end
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_op1       = ex_q.op1;
  assign bus.ex_op2       = ex_q.op2;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rs2       = ex_q.rs2;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_alu_op    = ex_q.alu_op;
  assign bus.ex_alu_src   = ex_q.alu_src;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_mem_write = ex_q.mem_write;
  assign bus.stall_id     = stall;
  assign bus.hazard_count = hc_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter: BYPASS_EN, 1, when 1 enables writeback-to-EX bypass of operands; when 0 register file data is captured unmodified.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_pc  in  32  PC of the decode instruction.
- id_rs1, id_rs2, id_rd  in  5 each  decoded register indices.
- id_imm  in  32  sign-extended immediate.
- id_alu_op  in  4  ALU operation code.
- id_alu_src, id_reg_write, id_mem_read, id_mem_write  in  1 each  decoded controls.
- read_data1, read_data2  in  32 each  combinational register file read data for id_rs1/id_rs2.
- wb_rd  in  5, wb_data  in  32, wb_reg_write  in  1  writeback port, the same signals that drive the register file.
- flush  in  1  branch/jump resolved taken in EX; kill the decode instruction.
- ex_valid  out  1; ex_pc, ex_imm, ex_op1, ex_op2  out  32 each; ex_rs1, ex_rs2, ex_rd  out  5 each; ex_alu_op  out  4; ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered EX-stage bundle.
- stall_id  out  1  combinational; decode and fetch SHALL hold when high.
- hazard_count  out  16  number of load-use bubbles inserted.

Function
REQ-003 Load-use hazard SHALL be: stall_id = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
REQ-004 stall_id SHALL be forced to 0 when flush is 1.
REQ-005 Each rising edge, with reset low, priority SHALL be: flush > stall > load.
REQ-006 Flush: ex_valid <= 0 and ex_reg_write, ex_mem_read, ex_mem_write <= 0; other ex_* fields are don't-care.
REQ-007 Stall (stall_id = 1): bubble inserted; ex_valid and all three write/read controls <= 0; hazard_count increments.
REQ-008 Load: ex_valid <= id_valid; all ex_* fields <= the corresponding id_* values; controls are gated so ex_reg_write/ex_mem_read/ex_mem_write are 0 whenever id_valid is 0.
REQ-009 Operand capture for op1: if BYPASS_EN & wb_reg_write & (wb_rd != 0) & (wb_rd == id_rs1) then ex_op1 <= wb_data, else ex_op1 <= read_data1; op2 is identical using id_rs2/read_data2.
REQ-010 Bypass SHALL never select wb_data for index 0; id_rs1 = 0 SHALL yield ex_op1 = 0 regardless of read_data1.
REQ-011 hazard_count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-012 Latency SHALL be exactly one cycle from decode to EX outputs; no output other than stall_id is combinational from inputs.
REQ-013 Simultaneous flush and hazard: flush wins, no bubble is counted, and stall_id is 0.
REQ-014 Bypass and hazard SHALL be evaluated independently; a bypass hit never suppresses stall_id.

Reset
REQ-015 When reset is high at a rising edge, all ex_* outputs and hazard_count SHALL be 0, overriding flush, stall and load.
REQ-016 During reset, stall_id SHALL evaluate to 0 (ex_valid is 0); the first edge after reset deassertion SHALL perform a normal load.

Verification
REQ-017 Plain load: id_valid=1, id_rs1=5, read_data1=32'h1234, no writeback -> next cycle ex_valid=1, ex_op1=32'h1234.
REQ-018 Bypass: id_rs2=7, read_data2=32'h0, wb_reg_write=1, wb_rd=7, wb_data=32'hDEAD_BEEF -> ex_op2=32'hDEAD_BEEF. With BYPASS_EN=0 -> ex_op2=0.
REQ-019 x0 bypass: id_rs1=0, wb_rd=0, wb_reg_write=1, wb_data=32'hFFFF_FFFF -> ex_op1=0.
REQ-020 Load-use: EX holds lw with ex_rd=3; ID instruction has id_rs1=3 -> stall_id=1, next cycle ex_valid=0, hazard_count=1; the following cycle the held instruction loads.
REQ-021 Flush during hazard: same as REQ-020 plus flush=1 -> stall_id=0, ex_valid=0, hazard_count unchanged.
REQ-022 Reset mid-run: hazard_count=5 and ex_valid=1, then reset=1 for one edge -> all outputs 0. Saturation: preload 16'hFFFF, then one more stall -> count stays 16'hFFFF.
